// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: the per-channel
// state encoding and the width of the debounce and repeat counters.
package button_pkg;

  localparam int BTN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchroniser, debounce filter, and a
// press/auto-repeat state machine that raises pulse_req for one cycle per
// press and per repeat tick. pulse_req is combinational; the top registers it.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 256,
  parameter int unsigned REPEAT_RATE     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic held,
  output logic pulse_req
);

  // Counter targets narrowed to counter width. The delay target is only
  // consulted when auto-repeat is enabled, so its value for a zero delay
  // does not matter.
  localparam logic [BTN_CNT_W-1:0] DEB_TGT  = BTN_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [BTN_CNT_W-1:0] DLY_TGT  = BTN_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [BTN_CNT_W-1:0] RATE_TGT = BTN_CNT_W'(REPEAT_RATE - 1);
  localparam bit                   RPT_EN   = (REPEAT_DELAY != 0);

  logic                 sync1_q, sync2_q;
  logic                 lvl_q, lvl_d;
  logic [BTN_CNT_W-1:0] dcnt_q, dcnt_d;
  logic [BTN_CNT_W-1:0] rcnt_q, rcnt_d;
  btn_state_e           state_q, state_d;

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    if (sync2_q == lvl_q) begin
      dcnt_d = '0;
    end else if (dcnt_q + 1'b1 == DEB_TGT) begin
      lvl_d  = ~lvl_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Press/repeat state machine: pulse on press, then after the delay, then every rate period.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    pulse_req = 1'b0;
    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (lvl_q) begin
          pulse_req = 1'b1;
          state_d   = HELD;
        end
      end
      HELD: begin
        if (!lvl_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (RPT_EN && (rcnt_q == DLY_TGT)) begin
          pulse_req = 1'b1;
          rcnt_d    = '0;
          state_d   = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!lvl_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RATE_TGT) begin
          pulse_req = 1'b1;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // State, level and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign held = lvl_q;

endmodule

// File: rtl/button_conditioner.sv
// Two-channel plus/minus button front end. Each channel is conditioned by a
// debounce_channel; simultaneous requests cancel so the downstream counter
// sees no net change, and accepted requests become registered one-cycle pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 256,
  parameter int unsigned REPEAT_RATE     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_plus_raw,
  input  logic btn_minus_raw,
  output logic button_plus,
  output logic button_minus,
  output logic plus_held,
  output logic minus_held
);

  logic req_plus, req_minus;
  logic button_plus_q, button_plus_d;
  logic button_minus_q, button_minus_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_plus (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_plus_raw),
    .held     (plus_held),
    .pulse_req(req_plus)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_minus (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_minus_raw),
    .held     (minus_held),
    .pulse_req(req_minus)
  );

  // Arbitration: a lone request passes, coincident requests are both dropped.
  always_comb begin
    button_plus_d  = req_plus & ~req_minus;
    button_minus_d = req_minus & ~req_plus;
  end

  // Output pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      button_plus_q  <= 1'b0;
      button_minus_q <= 1'b0;
    end else begin
      button_plus_q  <= button_plus_d;
      button_minus_q <= button_minus_d;
    end
  end

  assign button_plus  = button_plus_q;
  assign button_minus = button_minus_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios followed by random
// button activity, every cycle compared against a behavioural model that
// predicts pulses from the time elapsed since the debounced level rose.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;

  logic clk;
  logic rst;
  logic btn_plus_raw;
  logic btn_minus_raw;
  logic button_plus;
  logic button_minus;
  logic plus_held;
  logic minus_held;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = plus, 1 = minus.
  logic m_s1  [2] = '{1'b0, 1'b0};
  logic m_s2  [2] = '{1'b0, 1'b0};
  logic m_lvl [2] = '{1'b0, 1'b0};
  int   m_cnt [2] = '{0, 0};
  int   m_age [2] = '{0, 0};
  logic exp_plus  = 1'b0;
  logic exp_minus = 1'b0;

  int plus_cnt  = 0;
  int minus_cnt = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_plus_raw (btn_plus_raw),
    .btn_minus_raw(btn_minus_raw),
    .button_plus  (button_plus),
    .button_minus (button_minus),
    .plus_held    (plus_held),
    .minus_held   (minus_held)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one rising edge given the inputs sampled at it.
  // A channel whose debounced level has been high for 'age' cycles requests a
  // pulse at age 0, and at DLY, DLY+RATE, DLY+2*RATE, ... when repeat is on.
  task automatic modelStep(input logic r, input logic rp, input logic rm);
    logic req [2];
    logic raw [2];
    logic lvl_new;
    raw[0] = rp;
    raw[1] = rm;
    if (!r) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
        m_cnt[ch] = 0;   m_age[ch] = 0;
      end
      exp_plus  = 1'b0;
      exp_minus = 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        req[ch] = m_lvl[ch] && ((m_age[ch] == 0) ||
                  ((DLY != 0) && (m_age[ch] >= DLY) && ((m_age[ch] - DLY) % RATE == 0)));
      end
      exp_plus  = req[0] & ~req[1];
      exp_minus = req[1] & ~req[0];
      for (int ch = 0; ch < 2; ch++) begin
        lvl_new = m_lvl[ch];
        if (m_s2[ch] == m_lvl[ch]) begin
          m_cnt[ch] = 0;
        end else begin
          m_cnt[ch]++;
          if (m_cnt[ch] == DEB) begin
            lvl_new   = ~lvl_new;
            m_cnt[ch] = 0;
          end
        end
        m_age[ch] = (m_lvl[ch] && lvl_new) ? m_age[ch] + 1 : 0;
        m_lvl[ch] = lvl_new;
        m_s2[ch]  = m_s1[ch];
        m_s1[ch]  = raw[ch];
      end
    end
  endtask

  // Hold the given inputs for n cycles, checking every output after each edge.
  task automatic applyStimulus(input logic r, input logic p, input logic m, input int n);
    for (int i = 0; i < n; i++) begin
      rst           = r;
      btn_plus_raw  = p;
      btn_minus_raw = m;
      @(posedge clk);
      modelStep(r, p, m);
      #1;
      checkOutput("button_plus", 32'(button_plus), 32'(exp_plus));
      checkOutput("button_minus", 32'(button_minus), 32'(exp_minus));
      checkOutput("plus_held", 32'(plus_held), 32'(m_lvl[0]));
      checkOutput("minus_held", 32'(minus_held), 32'(m_lvl[1]));
      if (button_plus === 1'b1)  plus_cnt++;
      if (button_minus === 1'b1) minus_cnt++;
    end
  endtask

  initial begin
    int dur_p;
    int dur_m;
    logic rp;
    logic rm;
    rst           = 1'b0;
    btn_plus_raw  = 1'b0;
    btn_minus_raw = 1'b0;

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("reset_plus", 32'(button_plus), 32'd0);
    checkOutput("reset_minus", 32'(button_minus), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);

    // Clean press: one pulse within ten held cycles, none on release.
    plus_cnt = 0; minus_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    checkOutput("clean_plus_count", 32'(plus_cnt), 32'd1);
    checkOutput("clean_minus_count", 32'(minus_cnt), 32'd0);

    // Bounce then settle on minus.
    plus_cnt = 0; minus_cnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    checkOutput("bounce_minus_count", 32'(minus_cnt), 32'd1);

    // Auto-repeat: pulses at t0, +20, +28, +36, +44, +52 over 60 held cycles.
    plus_cnt = 0; minus_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkOutput("repeat_plus_count", 32'(plus_cnt), 32'd6);

    // Simultaneous press cancels both channels.
    plus_cnt = 0; minus_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 15);
    checkOutput("simul_plus_held", 32'(plus_held), 32'd1);
    checkOutput("simul_minus_held", 32'(minus_held), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    checkOutput("simul_plus_count", 32'(plus_cnt), 32'd0);
    checkOutput("simul_minus_count", 32'(minus_cnt), 32'd0);

    // Reset in the middle of a hold: the held button counts as a new press.
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("midrst_held", 32'(plus_held), 32'd0);
    plus_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("midrst_plus_count", 32'(plus_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 12);

    // Random button activity with bounces, long holds and occasional resets.
    rp = 1'b0; rm = 1'b0;
    dur_p = 1; dur_m = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (--dur_p <= 0) begin
        rp    = ~rp;
        dur_p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 70));
      end
      if (--dur_m <= 0) begin
        rm    = ~rm;
        dur_m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 70));
      end
      if ($urandom_range(0, 399) == 0)
        applyStimulus(1'b0, rp, rm, int'($urandom_range(1, 3)));
      else
        applyStimulus(1'b1, rp, rm, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
